// File: rtl/edge_pkg.sv
// Shared types and BMP header constants for the edge-detect input path.
// Provides the frame FSM state enum and the header byte expectation helper.
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIXEL,
    ST_DONE
  } state_t;

  localparam logic [7:0] BMP_MAGIC_B = 8'h42;
  localparam logic [7:0] BMP_MAGIC_M = 8'h4D;

  localparam int OFF_WIDTH  = 18;
  localparam int OFF_HEIGHT = 22;
  localparam int OFF_BPP    = 28;

  localparam int BMP_BPP         = 24;
  localparam int BMP_HEADER_SIZE = 54;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } hdr_exp_t;

  // Expected value of header byte k; chk=0 marks don't-care bytes.
  function automatic hdr_exp_t hdr_expect(
    input int k,
    input int w,
    input int h
  );
    hdr_exp_t e;
    e.chk = 1'b0;
    e.val = 8'h00;
    if (k == 0) begin
      e.chk = 1'b1;
      e.val = BMP_MAGIC_B;
    end else if (k == 1) begin
      e.chk = 1'b1;
      e.val = BMP_MAGIC_M;
    end else if (k >= OFF_WIDTH &&
                 k < OFF_WIDTH + 4) begin
      e.chk = 1'b1;
      e.val = 8'(w >> (8 * (k - OFF_WIDTH)));
    end else if (k >= OFF_HEIGHT &&
                 k < OFF_HEIGHT + 4) begin
      e.chk = 1'b1;
      e.val = 8'(h >> (8 * (k - OFF_HEIGHT)));
    end else if (k == OFF_BPP) begin
      e.chk = 1'b1;
      e.val = 8'(BMP_BPP);
    end else if (k == OFF_BPP + 1) begin
      e.chk = 1'b1;
      e.val = 8'h00;
    end
    return e;
  endfunction

endpackage

// File: rtl/bmp_pixel_packer.sv
// Packs three pixel bytes into one 24-bit push, first byte in [23:16].
// Ports: i_en/i_clr from the FSM, byte FIFO pop side, pixel FIFO push side.
module bmp_pixel_packer
  import edge_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_byte_empty,
  input  logic        i_pix_full,
  input  logic [7:0]  i_byte_dout,
  output logic        o_byte_rd_en,
  output logic        o_pix_wr_en,
  output logic [23:0] o_pix_din
);

  logic [1:0] r_phase;
  logic [7:0] r_b0;
  logic [7:0] r_b1;

  logic w_ph2;
  logic w_push;
  logic w_pop;

  assign w_ph2 = (r_phase == 2'd2);

  // The third byte is only taken when it can be pushed in the same cycle.
  assign w_push = i_en && w_ph2 &&
                  !i_byte_empty && !i_pix_full;
  assign w_pop  = w_ph2 ? w_push
                        : (i_en && !i_byte_empty);

  assign o_byte_rd_en = w_pop;
  assign o_pix_wr_en  = w_push;
  assign o_pix_din    = w_push ?
                        {r_b0, r_b1, i_byte_dout} :
                        24'h0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 2'd0;
      r_b0    <= 8'h00;
      r_b1    <= 8'h00;
    end else if (i_clr) begin
      r_phase <= 2'd0;
    end else if (w_pop) begin
      unique case (1'b1)
        (r_phase == 2'd0): begin
          r_b0    <= i_byte_dout;
          r_phase <= 2'd1;
        end
        (r_phase == 2'd1): begin
          r_b1    <= i_byte_dout;
          r_phase <= 2'd2;
        end
        default: begin
          r_phase <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bmp_frame_ctrl.sv
// BMP frame sequencer: header check, pixel packing, frame accounting.
// Ports: i_start/o_busy/o_done/o_hdr_error/o_frame_count, byte and pixel FIFOs.
module bmp_frame_ctrl
  import edge_pkg::*;
#(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int HDR_BYTES = BMP_HEADER_SIZE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_hdr_error,
  output logic [15:0] o_frame_count,
  input  logic        i_byte_empty,
  output logic        o_byte_rd_en,
  input  logic [7:0]  i_byte_dout,
  input  logic        i_pix_full,
  output logic        o_pix_wr_en,
  output logic [23:0] o_pix_din
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int IW   = (HDR_BYTES > 1) ?
                        $clog2(HDR_BYTES) : 1;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0] r_idx;
  logic [PW-1:0] r_pix_cnt;
  logic          r_err;
  logic          r_hdr_error;
  logic [15:0]   r_frame_count;

  logic     w_accept;
  logic     w_hdr_pop;
  logic     w_hdr_last;
  logic     w_mismatch;
  logic     w_pix_last;
  logic     w_pk_en;
  logic     w_pk_rd;
  logic     w_push;
  logic     w_rd_en;
  hdr_exp_t w_exp;

  assign w_accept = (r_state == ST_IDLE) && i_start;

  assign w_hdr_pop  = (r_state == ST_HEADER) &&
                      !i_byte_empty;
  assign w_hdr_last = (r_idx == IW'(HDR_BYTES - 1));

  assign w_exp      = hdr_expect(int'(r_idx),
                                 WIDTH, HEIGHT);
  assign w_mismatch = w_exp.chk &&
                      (i_byte_dout != w_exp.val);

  assign w_pix_last = (r_pix_cnt == PW'(NPIX - 1));
  assign w_pk_en    = (r_state == ST_PIXEL);

  bmp_pixel_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (w_pk_en),
    .i_clr        (w_accept),
    .i_byte_empty (i_byte_empty),
    .i_pix_full   (i_pix_full),
    .i_byte_dout  (i_byte_dout),
    .o_byte_rd_en (w_pk_rd),
    .o_pix_wr_en  (w_push),
    .o_pix_din    (o_pix_din)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_HEADER;
      end
      ST_HEADER: begin
        // The full header is always drained before deciding.
        if (w_hdr_pop && w_hdr_last) begin
          w_next = (r_err || w_mismatch) ?
                   ST_DONE : ST_PIXEL;
        end
      end
      ST_PIXEL: begin
        if (w_push && w_pix_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_busy  = 1'b0;
    o_done  = 1'b0;
    w_rd_en = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
      end
      ST_HEADER: begin
        o_busy  = 1'b1;
        w_rd_en = !i_byte_empty;
      end
      ST_PIXEL: begin
        o_busy  = 1'b1;
        w_rd_en = w_pk_rd;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_byte_rd_en  = w_rd_en;
  assign o_pix_wr_en   = w_push;
  assign o_hdr_error   = r_hdr_error;
  assign o_frame_count = r_frame_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx         <= '0;
      r_pix_cnt     <= '0;
      r_err         <= 1'b0;
      r_hdr_error   <= 1'b0;
      r_frame_count <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_idx       <= '0;
        r_pix_cnt   <= '0;
        r_err       <= 1'b0;
        r_hdr_error <= 1'b0;
      end
      if (w_hdr_pop) begin
        r_idx <= r_idx + 1'b1;
        if (w_mismatch) r_err <= 1'b1;
        // Flag becomes visible in the done cycle.
        if (w_hdr_last && (r_err || w_mismatch)) begin
          r_hdr_error <= 1'b1;
        end
      end
      if (w_push) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      if (r_state == ST_DONE && !r_err) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bmp_frame_ctrl.sv
// Scoreboard bench for bmp_frame_ctrl with a 4x2 frame.
// Host FIFO model, pixel/done scoreboards and directed frame scenarios.
module tb_bmp_frame_ctrl;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int HB  = 54;
  localparam int MIN_CYC = 1 + HB + 3 * W * H + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        hdr_error;
  logic [15:0] frame_count;
  logic        byte_empty = 1'b1;
  logic        byte_rd_en;
  logic [7:0]  byte_dout = 8'h00;
  logic        pix_full = 1'b0;
  logic        pix_wr_en;
  logic [23:0] pix_din;

  always #5 clk = ~clk;

  bmp_frame_ctrl #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .HDR_BYTES (HB)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_hdr_error   (hdr_error),
    .o_frame_count (frame_count),
    .i_byte_empty  (byte_empty),
    .o_byte_rd_en  (byte_rd_en),
    .i_byte_dout   (byte_dout),
    .i_pix_full    (pix_full),
    .o_pix_wr_en   (pix_wr_en),
    .o_pix_din     (pix_din)
  );

  logic [23:0] EXP_PIX [8] = '{
    24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C,
    24'h0D0E0F, 24'h101112, 24'h131415, 24'h161718
  };

  logic [7:0]  fifo[$];
  logic [23:0] exp_pix[$];
  logic        exp_done[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_push = 0;
  int pops = 0;
  int stall_cnt = 0;
  int start_cyc = 0;
  int cyc_mode = 0;
  bit rand_mode = 0;
  bit stall_mode = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Host byte FIFO (first-word-fall-through) and pixel FIFO full model.
  initial forever begin
    @(posedge clk);
    if (rst_n && byte_rd_en) begin
      chk("pop_while_empty", 32'(byte_empty), 32'd0);
      if (fifo.size() > 0) begin
        void'(fifo.pop_front());
        pops++;
      end
    end
    #1;
    // Stall exactly while pixel 3 (bytes 9..11) waits in phase 2.
    pix_full = stall_mode && (pops == HB + 11) &&
               (stall_cnt < 10);
    if (pix_full) stall_cnt++;
    byte_empty = (fifo.size() == 0) ||
                 (rand_mode && ($urandom_range(0, 1) == 1));
    byte_dout = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Monitor: compares every push and done against the scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_wr_en) begin
        n_push++;
        if (exp_pix.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got 0x%06h expected none",
                   pix_din);
        end else begin
          chk("pix_din", 32'(pix_din),
              32'(exp_pix.pop_front()));
        end
      end
      if (done) begin
        int d;
        n_done++;
        d = cyc - start_cyc + 1;
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          chk("done_hdr_error", 32'(hdr_error),
              32'(exp_done.pop_front()));
        end
        if (cyc_mode == 1)
          chk("frame_cycles_min", 32'(d), 32'(MIN_CYC));
        if (cyc_mode == 2)
          chk("frame_cycles_gt_min",
              32'(d > MIN_CYC), 32'd1);
      end
      if (pix_full)
        chk("stall_rd_en", 32'(byte_rd_en), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] hdr_byte(input int k,
                                          input bit bad);
    case (k)
      0:  return 8'h42;
      1:  return 8'h4D;
      18: return bad ? 8'h05 : 8'h04;
      19, 20, 21: return 8'h00;
      22: return 8'h02;
      23, 24, 25: return 8'h00;
      26: return 8'h01;
      27: return 8'h00;
      28: return 8'h18;
      29: return 8'h00;
      default: return 8'(k * 7 + 3);
    endcase
  endfunction

  task automatic load_frame(input bit bad);
    pops = 0;
    stall_cnt = 0;
    for (int k = 0; k < HB; k++)
      fifo.push_back(hdr_byte(k, bad));
    if (!bad) begin
      for (int i = 0; i < 3 * W * H; i++)
        fifo.push_back(8'(i + 1));
      for (int i = 0; i < W * H; i++)
        exp_pix.push_back(EXP_PIX[i]);
    end
    exp_done.push_back(bad);
  endtask

  task automatic start_frame();
    tick();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = n_done;
    int i = 0;
    while (n_done == d0 && i < 3000) begin
      tick();
      i++;
    end
    if (n_done == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done");
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_hdr_error"}, 32'(hdr_error), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_byte_rd_en"}, 32'(byte_rd_en), 32'd0);
    chk({tag, "_pix_wr_en"}, 32'(pix_wr_en), 32'd0);
    chk({tag, "_pix_din"}, 32'(pix_din), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;

    // Width byte 0x05: header fully drained, no pixels, flagged.
    load_frame(1'b1);
    cyc_mode = 0;
    start_frame();
    wait_done();
    chk("err_hdr_consumed", 32'(fifo.size()), 32'd0);
    chk("err_hdr_error", 32'(hdr_error), 32'd1);
    chk("err_frame_count", 32'(frame_count), 32'd0);

    // Clean frame, no stalls: exact minimum frame time.
    load_frame(1'b0);
    cyc_mode = 1;
    start_frame();
    chk("start_clears_hdr_error", 32'(hdr_error), 32'd0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    wait_done();
    chk("ok_frame_count", 32'(frame_count), 32'd1);
    chk("ok_hdr_error", 32'(hdr_error), 32'd0);
    chk("ok_idle", 32'(busy), 32'd0);

    // Pixel FIFO full for 10 cycles at pixel 3.
    load_frame(1'b0);
    cyc_mode = 0;
    stall_mode = 1;
    start_frame();
    wait_done();
    stall_mode = 0;
    chk("stall_cycles", 32'(stall_cnt), 32'd10);
    chk("stall_frame_count", 32'(frame_count), 32'd2);

    // Random byte_empty and an ignored start during the header.
    load_frame(1'b0);
    cyc_mode = 2;
    rand_mode = 1;
    start_frame();
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    rand_mode = 0;
    repeat (4) tick();
    chk("no_queued_start_busy", 32'(busy), 32'd0);
    chk("rand_frame_count", 32'(frame_count), 32'd3);

    // Reset during PIXEL, then a fresh frame.
    load_frame(1'b0);
    cyc_mode = 0;
    begin
      int base = n_push;
      int i = 0;
      start_frame();
      while (n_push < base + 2 && i < 500) begin
        tick();
        i++;
      end
      chk("reached_pixel", 32'(n_push >= base + 2), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    fifo.delete();
    exp_pix.delete();
    exp_done.delete();
    tick();
    tick();
    rst_n = 1'b1;
    load_frame(1'b0);
    cyc_mode = 1;
    start_frame();
    wait_done();
    chk("fresh_frame_count", 32'(frame_count), 32'd1);
    chk("fresh_hdr_error", 32'(hdr_error), 32'd0);

    chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
